// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO.
// Fill/free-space codes are common to POP_FLAG and PUSH_FLAG.
package sync_fifo_pkg;

    localparam logic [3:0] FLAG_ZERO  = 4'h0;
    localparam logic [3:0] FLAG_ONE   = 4'h1;
    localparam logic [3:0] FLAG_LT_Q  = 4'h2;
    localparam logic [3:0] FLAG_LT_H  = 4'h3;
    localparam logic [3:0] FLAG_LT_3Q = 4'h4;
    localparam logic [3:0] FLAG_GE_3Q = 4'h5;

    // depth >= 8, so depth/4 >= 2 and the ranges below never overlap
    function automatic logic [3:0] level_code(
        input int unsigned level,
        input int unsigned depth
    );
        logic [3:0] code;
        code = FLAG_ZERO;
        unique case (1'b1)
            (level == 0):
                code = FLAG_ZERO;
            (level == 1):
                code = FLAG_ONE;
            (level >= 2 && level < depth / 4):
                code = FLAG_LT_Q;
            (level >= depth / 4 && level < depth / 2):
                code = FLAG_LT_H;
            (level >= depth / 2 && level < (3 * depth) / 4):
                code = FLAG_LT_3Q;
            (level >= (3 * depth) / 4):
                code = FLAG_GE_3Q;
            default:
                code = FLAG_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// wr_fwd selects write-first behaviour on an address collision.
module fifo_mem_sdp
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 2048
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_clr,
    input  logic                          wr_fwd,
    input  logic                          we,
    input  logic [$clog2(DATA_DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          re,
    input  logic [$clog2(DATA_DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]         rdata
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic                  hit;

    assign hit = wr_fwd & we & (waddr == raddr);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= hit ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, level codes,
// sticky overflow/underflow flags, synchronous flush and optional FWFT read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 2048,
    parameter int AF_THRESH  = 4,
    parameter int AE_THRESH  = 4,
    parameter int FWFT       = 0
) (
    input  logic                          Clk,
    input  logic                          Async_Flush,
    input  logic                          Clk_En,
    input  logic                          Fifo_Flush,
    input  logic                          PUSH,
    input  logic [DATA_WIDTH-1:0]         DIN,
    input  logic                          POP,
    output logic [DATA_WIDTH-1:0]         DOUT,
    output logic [3:0]                    PUSH_FLAG,
    output logic [3:0]                    POP_FLAG,
    output logic                          Almost_Full,
    output logic                          Almost_Empty,
    output logic [$clog2(DATA_DEPTH):0]   Count,
    output logic                          Overflow,
    output logic                          Underflow
);

    localparam int   AW  = $clog2(DATA_DEPTH);
    localparam int   CW  = AW + 1;
    localparam logic FWD = (FWFT != 0);

    localparam logic [CW-1:0] FULL = CW'(DATA_DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_nx;
    logic [AW-1:0] wr_nx;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] free_nx;
    logic          pop_ok;
    logic          push_ok;
    logic          ovf_nx;
    logic          unf_nx;
    logic          act;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;

    always_comb begin
        pop_ok  = POP & (Count != '0);
        push_ok = PUSH & ((Count != FULL) | pop_ok);
        if (Fifo_Flush) begin
            cnt_nx = '0;
            rd_nx  = '0;
            wr_nx  = '0;
            ovf_nx = 1'b0;
            unf_nx = 1'b0;
        end else begin
            cnt_nx = Count + CW'(push_ok) - CW'(pop_ok);
            rd_nx  = rd_ptr + AW'(pop_ok);
            wr_nx  = wr_ptr + AW'(push_ok);
            ovf_nx = Overflow | (PUSH & ~push_ok);
            unf_nx = Underflow | (POP & ~pop_ok);
        end
        free_nx = FULL - cnt_nx;
    end

    assign act    = Clk_En & ~Fifo_Flush;
    assign mem_we = act & push_ok;

    // FWFT reads the next head every cycle the FIFO stays non-empty
    assign mem_re    = act & (FWD ? (cnt_nx != '0) : pop_ok);
    assign mem_raddr = FWD ? rd_nx : rd_ptr;

    fifo_mem_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_mem (
        .clk    (Clk),
        .rst    (Async_Flush),
        .rd_clr (Clk_En & Fifo_Flush),
        .wr_fwd (FWD),
        .we     (mem_we),
        .waddr  (wr_ptr),
        .wdata  (DIN),
        .re     (mem_re),
        .raddr  (mem_raddr),
        .rdata  (DOUT)
    );

    always_ff @(posedge Clk or posedge Async_Flush) begin
        if (Async_Flush) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            Count        <= '0;
            POP_FLAG     <= FLAG_ZERO;
            PUSH_FLAG    <= FLAG_GE_3Q;
            Almost_Empty <= 1'b1;
            Almost_Full  <= 1'b0;
            Overflow     <= 1'b0;
            Underflow    <= 1'b0;
        end else if (Clk_En) begin
            rd_ptr       <= rd_nx;
            wr_ptr       <= wr_nx;
            Count        <= cnt_nx;
            POP_FLAG     <= level_code(32'(cnt_nx), DATA_DEPTH);
            PUSH_FLAG    <= level_code(32'(free_nx), DATA_DEPTH);
            Almost_Empty <= (cnt_nx <= CW'(AE_THRESH));
            Almost_Full  <= (free_nx <= CW'(AF_THRESH));
            Overflow     <= ovf_nx;
            Underflow    <= unf_nx;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered and FWFT instances share stimulus
// and are checked against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int D  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;

    logic [DW-1:0] r_dout, f_dout;
    logic [3:0]    r_pushf, r_popf, f_pushf, f_popf;
    logic          r_af, r_ae, f_af, f_ae;
    logic          r_ovf, r_unf, f_ovf, f_unf;
    logic [CW-1:0] r_cnt, f_cnt;

    sync_fifo_param #(
        .DATA_WIDTH (DW), .DATA_DEPTH (D),
        .AF_THRESH (4), .AE_THRESH (4), .FWFT (0)
    ) u_reg (
        .Clk (clk), .Async_Flush (rst), .Clk_En (en),
        .Fifo_Flush (flush), .PUSH (push), .DIN (din), .POP (pop),
        .DOUT (r_dout), .PUSH_FLAG (r_pushf), .POP_FLAG (r_popf),
        .Almost_Full (r_af), .Almost_Empty (r_ae), .Count (r_cnt),
        .Overflow (r_ovf), .Underflow (r_unf)
    );

    sync_fifo_param #(
        .DATA_WIDTH (DW), .DATA_DEPTH (D),
        .AF_THRESH (4), .AE_THRESH (4), .FWFT (1)
    ) u_fwft (
        .Clk (clk), .Async_Flush (rst), .Clk_En (en),
        .Fifo_Flush (flush), .PUSH (push), .DIN (din), .POP (pop),
        .DOUT (f_dout), .PUSH_FLAG (f_pushf), .POP_FLAG (f_popf),
        .Almost_Full (f_af), .Almost_Empty (f_ae), .Count (f_cnt),
        .Overflow (f_ovf), .Underflow (f_unf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int q[$];
    bit m_ovf, m_unf;
    int m_dr, m_df;

    typedef struct {
        bit          en, fl, pu, po;
        logic [7:0]  din;
        int          cnt;
        bit          ovf, unf;
        logic [7:0]  dr, df;
    } vec_t;

    vec_t tv[8];

    task automatic cmp(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int flag_code(input int n);
        int c;
        if (n == 0) return 0;
        if (n == 1) return 1;
        c = 2 + (n * 4) / D;
        return (c > 5) ? 5 : c;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_dr  = 0;
        m_df  = 0;
    endtask

    task automatic model_step();
        bit pop_ok, push_ok;
        if (!en) return;
        if (flush) begin
            model_reset();
            return;
        end
        pop_ok  = pop && q.size() != 0;
        push_ok = push && (q.size() != D || pop_ok);
        if (pop_ok) m_dr = q.pop_front();
        if (push_ok) q.push_back(int'(din));
        if (push && !push_ok) m_ovf = 1;
        if (pop && !pop_ok) m_unf = 1;
        if (q.size() != 0) m_df = q[0];
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        cmp("r_count", 64'(r_cnt), 64'(n));
        cmp("f_count", 64'(f_cnt), 64'(n));
        cmp("r_pop_flag", 64'(r_popf), 64'(flag_code(n)));
        cmp("f_pop_flag", 64'(f_popf), 64'(flag_code(n)));
        cmp("r_push_flag", 64'(r_pushf), 64'(flag_code(D - n)));
        cmp("f_push_flag", 64'(f_pushf), 64'(flag_code(D - n)));
        cmp("r_almost_full", 64'(r_af), 64'((D - n) <= 4));
        cmp("f_almost_full", 64'(f_af), 64'((D - n) <= 4));
        cmp("r_almost_empty", 64'(r_ae), 64'(n <= 4));
        cmp("f_almost_empty", 64'(f_ae), 64'(n <= 4));
        cmp("r_overflow", 64'(r_ovf), 64'(m_ovf));
        cmp("f_overflow", 64'(f_ovf), 64'(m_ovf));
        cmp("r_underflow", 64'(r_unf), 64'(m_unf));
        cmp("f_underflow", 64'(f_unf), 64'(m_unf));
        cmp("r_dout", 64'(r_dout), 64'(m_dr));
        cmp("f_dout", 64'(f_dout), 64'(m_df));
    endtask

    task automatic step(input bit e, input bit f, input bit pu,
                        input bit po, input logic [7:0] d);
        en    = e;
        flush = f;
        push  = pu;
        pop   = po;
        din   = d;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // reset pulse placed between clock edges
    task automatic async_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        cmp("async_count", 64'(r_cnt), 64'd0);
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tv[0] = '{1, 0, 1, 0, 8'hA5, 1, 0, 0, 8'h00, 8'hA5};
        tv[1] = '{1, 0, 0, 1, 8'h00, 0, 0, 0, 8'hA5, 8'hA5};
        tv[2] = '{1, 0, 0, 1, 8'h00, 0, 0, 1, 8'hA5, 8'hA5};
        tv[3] = '{1, 0, 1, 1, 8'h11, 1, 0, 1, 8'hA5, 8'h11};
        tv[4] = '{1, 0, 1, 1, 8'h22, 1, 0, 1, 8'h11, 8'h22};
        tv[5] = '{1, 1, 1, 0, 8'h33, 0, 0, 0, 8'h00, 8'h00};
        tv[6] = '{0, 0, 1, 0, 8'h44, 0, 0, 0, 8'h00, 8'h00};
        tv[7] = '{1, 0, 1, 0, 8'h55, 1, 0, 0, 8'h00, 8'h55};

        rst = 1'b1; en = 0; flush = 0; push = 0; pop = 0; din = '0;
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;

        foreach (tv[i]) begin
            step(tv[i].en, tv[i].fl, tv[i].pu, tv[i].po, tv[i].din);
            cmp($sformatf("tv%0d_count", i), 64'(r_cnt), 64'(tv[i].cnt));
            cmp($sformatf("tv%0d_ovf", i), 64'(f_ovf), 64'(tv[i].ovf));
            cmp($sformatf("tv%0d_unf", i), 64'(r_unf), 64'(tv[i].unf));
            cmp($sformatf("tv%0d_rdout", i), 64'(r_dout), 64'(tv[i].dr));
            cmp($sformatf("tv%0d_fdout", i), 64'(f_dout), 64'(tv[i].df));
        end

        // fill, then overflow
        async_pulse();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, 0, 8'(i));
            cmp("fill_af", 64'(r_af), 64'(i + 1 >= 12));
        end
        cmp("full_push_flag", 64'(r_pushf), 64'd0);
        cmp("full_pop_flag", 64'(r_popf), 64'd5);
        step(1, 0, 1, 0, 8'hEE);
        cmp("ovf_count", 64'(r_cnt), 64'd16);
        cmp("ovf_set", 64'(r_ovf), 64'd1);

        // drain in order, then underflow
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 1, 8'h00);
            cmp("drain_dout", 64'(r_dout), 64'(i));
            cmp("drain_ae", 64'(r_ae), 64'(16 - (i + 1) <= 4));
        end
        cmp("empty_pop_flag", 64'(r_popf), 64'd0);
        step(1, 0, 0, 1, 8'h00);
        cmp("unf_set", 64'(r_unf), 64'd1);
        cmp("unf_hold", 64'(r_dout), 64'h0F);

        // full with simultaneous push/pop across the pointer wrap
        async_pulse();
        for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 8'(i));
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 1, 8'(16 + i));
            cmp("pp_dout", 64'(r_dout), 64'(i));
            cmp("pp_count", 64'(r_cnt), 64'd16);
            cmp("pp_ovf", 64'(r_ovf), 64'd0);
        end

        // FWFT single word
        async_pulse();
        step(1, 0, 1, 0, 8'hA5);
        cmp("fwft_dout", 64'(f_dout), 64'hA5);
        step(1, 0, 0, 1, 8'h00);
        cmp("fwft_count", 64'(f_cnt), 64'd0);
        cmp("fwft_hold", 64'(f_dout), 64'hA5);

        // flush overriding a push at Count = 9 with Overflow set
        async_pulse();
        for (int i = 0; i < 17; i++) step(1, 0, 1, 0, 8'(i + 3));
        for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 8'h00);
        cmp("pre_flush_count", 64'(r_cnt), 64'd9);
        cmp("pre_flush_ovf", 64'(r_ovf), 64'd1);
        step(1, 1, 1, 0, 8'h77);
        cmp("flush_count", 64'(f_cnt), 64'd0);
        cmp("flush_ovf", 64'(f_ovf), 64'd0);
        cmp("flush_push_flag", 64'(r_pushf), 64'd5);
        cmp("flush_pop_flag", 64'(r_popf), 64'd0);

        // clock enable low freezes everything; async reset still acts
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 8'(i + 40));
        for (int i = 0; i < 10; i++) step(0, 0, i[0], ~i[0], 8'(i));
        cmp("freeze_count", 64'(r_cnt), 64'd5);
        async_pulse();
        step(0, 0, 1, 1, 8'h99);
        cmp("frozen_reset_count", 64'(f_cnt), 64'd0);

        // randomized traffic with drifting push/pop bias
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3 == 0 ? 75 : ((i / 100) % 3 == 1 ? 50 : 25);
            step($urandom_range(99) < 90,
                 $urandom_range(199) == 0,
                 $urandom_range(99) < bias,
                 $urandom_range(99) >= bias - 10,
                 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
